// File: rtl/arashi_wb_drain.sv
// Write-back drain buffer: FIFO of evicted words drained to the memory stage as an
// rcache strobe followed one cycle later by the word on cache2mem.
module arashi_wb_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3,
    parameter int THRESH     = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  rcache,
    output logic [DATA_WIDTH-1:0] cache2mem,
    output logic [DEPTH_LOG2:0]   count,
    output logic [CNT_WIDTH-1:0]  drained
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_C  = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   THRESH_C = THRESH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [CNT_WIDTH-1:0]  DRN_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    rcache_q, rcache_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [DATA_WIDTH-1:0]   c2m_q, c2m_d;
    logic                    done_q, done_d;
    logic                    pend_q, pend_d;
    logic [CNT_WIDTH-1:0]    drained_q, drained_d;
    logic                    full, push, pop, flush_any;

    assign full      = (count_q == DEPTH_C);
    assign push      = in_valid & ~full;
    // Pop looks at occupancy before this edge's push, so a word never bypasses the FIFO.
    assign pop       = (state_q != IDLE) && (count_q != '0);
    assign flush_any = flush_req | pend_q;

    always_comb begin
        wptr_d    = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d    = pop  ? rptr_q + PTR_ONE : rptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        rcache_d  = pop;
        hold_d    = pop ? mem_q[rptr_q] : hold_q;
        c2m_d     = rcache_q ? hold_q : c2m_q;
        drained_d = pop ? drained_q + DRN_ONE : drained_q;
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_any)                state_d = FLUSH;
                else if (count_q >= THRESH_C) state_d = DRAIN;
            end
            DRAIN: begin
                if (flush_any)                state_d = FLUSH;
                else if (count_d == '0)       state_d = IDLE;
            end
            FLUSH: begin
                // Wait until the last strobed word has landed on cache2mem and nothing new arrives.
                if (count_q == '0 && !rcache_q && !push) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Only a request that did not land in FLUSH is remembered.
        pend_d = flush_any && (state_d != FLUSH);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rcache_q  <= 1'b0;
            c2m_q     <= '0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
            drained_q <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rcache_q  <= rcache_d;
            c2m_q     <= c2m_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
            drained_q <= drained_d;
        end
    end

    // Storage and the skew register carry no reset; they are only read behind valid state.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= in_data;
        hold_q <= hold_d;
    end

    assign in_ready   = ~full;
    assign flush_done = done_q;
    assign rcache     = rcache_q;
    assign cache2mem  = c2m_q;
    assign count      = count_q;
    assign drained    = drained_q;

endmodule

// File: tb/tb_arashi_wb_drain.sv
// Bench for arashi_wb_drain: directed scenarios plus random traffic checked against a
// queue-based reference of the buffer's observable behaviour.
module tb_arashi_wb_drain;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TH    = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        in_valid, in_ready, flush_req, flush_done, rcache;
    logic [31:0] in_data, cache2mem;
    logic [3:0]  count;
    logic [15:0] drained;

    logic        v8, rdy8, fr8, fd8, rc8;
    logic [31:0] d8, c8;
    logic [3:0]  cnt8;
    logic [15:0] dr8;

    arashi_wb_drain #(.DATA_WIDTH(DW), .DEPTH_LOG2(3), .THRESH(TH), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush_req(flush_req), .flush_done(flush_done), .rcache(rcache),
        .cache2mem(cache2mem), .count(count), .drained(drained)
    );

    arashi_wb_drain #(.DATA_WIDTH(DW), .DEPTH_LOG2(3), .THRESH(8), .CNT_WIDTH(16)) u_dut8 (
        .clk(clk), .rstn(rstn), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
        .flush_req(fr8), .flush_done(fd8), .rcache(rc8),
        .cache2mem(c8), .count(cnt8), .drained(dr8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: FIFO contents, the word owed on cache2mem, and whether a drain or flush
    // is in progress (the only reasons a strobe may appear).
    logic [31:0] m_q[$];
    logic [31:0] got[$];
    logic [31:0] q8[$];
    bit          pend_v, flush_win, drain_act;
    logic [31:0] pend_w;
    int          n_pops, cyc, done_cyc, last_c2m_cyc, rc_cnt, rc_first, rc_last;

    task automatic model_reset();
        m_q.delete();
        got.delete();
        pend_v    = 1'b0;
        flush_win = 1'b0;
        drain_act = 1'b0;
        n_pops    = 0;
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit f);
        int prev_size;
        bit acc, fw, da;
        in_valid  = v;
        in_data   = d;
        flush_req = f;
        if (f) flush_win = 1'b1;
        prev_size = m_q.size();
        acc       = v && (prev_size < DEPTH);
        fw        = flush_win;
        da        = drain_act;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (pend_v) begin
            chk("c2m", cache2mem, pend_w);
            got.push_back(pend_w);
            last_c2m_cyc = cyc;
        end
        pend_v = 1'b0;
        if (acc) m_q.push_back(d);
        if (rcache) begin
            chk("pop_src", prev_size > 0, 1);
            chk("pop_reason", fw || da, 1);
            if (m_q.size() > 0) begin
                pend_w = m_q.pop_front();
                pend_v = 1'b1;
            end
            n_pops++;
            if (rc_cnt == 0) rc_first = cyc;
            rc_last = cyc;
            rc_cnt++;
        end
        chk("count", count, m_q.size());
        chk("in_ready", in_ready, m_q.size() < DEPTH);
        chk("drained", drained, n_pops & 16'hFFFF);
        if (m_q.size() >= TH) drain_act = 1'b1;
        if (m_q.size() == 0) drain_act = 1'b0;
        if (flush_done) begin
            chk("fd_expected", fw, 1);
            chk("fd_empty", m_q.size(), 0);
            chk("fd_no_strobe", rcache, 0);
            flush_win = 1'b0;
            done_cyc  = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic wait_flush(input int bound);
        int k = 0;
        while (flush_win && k < bound) begin
            step(1'b0, 32'h0, 1'b0);
            k++;
        end
        chk("flush_timeout", flush_win, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c_req;
        bit prev_rc;
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; flush_req = 1'b0;
        v8 = 1'b0; d8 = '0; fr8 = 1'b0;
        cyc = 0; rc_cnt = 0; rc_first = 0; rc_last = 0; done_cyc = 0; last_c2m_cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_rcache", rcache, 0);
        chk("rst_c2m", cache2mem, 0);
        chk("rst_count", count, 0);
        chk("rst_drained", drained, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_count8", cnt8, 0);
        rstn = 1'b1;

        // Threshold drain
        got.delete(); rc_cnt = 0;
        step(1'b1, 32'h11, 1'b0);
        step(1'b1, 32'h22, 1'b0);
        step(1'b1, 32'h33, 1'b0);
        idle(4);
        chk("t1_no_strobe", rc_cnt, 0);
        step(1'b1, 32'h44, 1'b0);
        idle(8);
        chk("t1_strobes", rc_cnt, 4);
        chk("t1_consec", rc_last - rc_first, 3);
        chk("t1_nwords", got.size(), 4);
        if (got.size() == 4) begin
            chk("t1_w0", got[0], 32'h11);
            chk("t1_w1", got[1], 32'h22);
            chk("t1_w2", got[2], 32'h33);
            chk("t1_w3", got[3], 32'h44);
        end
        chk("t1_drained", drained, 4);

        // Flush below threshold
        got.delete();
        step(1'b1, 32'hA, 1'b0);
        step(1'b1, 32'hB, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        wait_flush(20);
        chk("t3_nwords", got.size(), 2);
        if (got.size() == 2) begin
            chk("t3_w0", got[0], 32'hA);
            chk("t3_w1", got[1], 32'hB);
        end
        chk("t3_done_lat", done_cyc - last_c2m_cyc, 1);
        chk("t3_count", count, 0);

        // Empty flush
        rc_cnt = 0;
        c_req  = cyc;
        step(1'b0, 32'h0, 1'b1);
        wait_flush(10);
        chk("t5_done_lat", done_cyc - c_req, 2);
        chk("t5_no_strobe", rc_cnt, 0);

        // Streaming through the pointer wrap
        got.delete();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, i, 1'b0);
            if (i >= 5) begin
                chk("t4_rcache", rcache, 1);
                chk("t4_count", count, 5);
            end
        end
        idle(10);
        chk("t4_nwords", got.size(), 20);
        for (int i = 0; i < 20 && i < got.size(); i++) chk("t4_order", got[i], i);

        // Full FIFO on the THRESH=8 instance
        v8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d8 = k;
            @(posedge clk); @(negedge clk);
        end
        chk("t2_full_ready", rdy8, 0);
        chk("t2_full_count", cnt8, 8);
        d8 = 8;
        @(posedge clk); @(negedge clk);
        chk("t2_stall_count", cnt8, 8);
        chk("t2_stall_ready", rdy8, 0);
        chk("t2_stall_rc", rc8, 0);
        @(posedge clk); @(negedge clk);
        chk("t2_pop_rc", rc8, 1);
        chk("t2_pop_count", cnt8, 7);
        chk("t2_pop_ready", rdy8, 1);
        prev_rc = rc8;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 0) begin
                chk("t2_accept_count", cnt8, 7);
                v8 = 1'b0;
            end
            if (prev_rc) q8.push_back(c8);
            prev_rc = rc8;
        end
        chk("t2_nwords", q8.size(), 9);
        for (int i = 0; i < 9 && i < q8.size(); i++) chk("t2_order", q8[i], i);
        chk("t2_drained", dr8, 9);
        chk("t2_no_flush_done", fd8, 0);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 6; i++) step(1'b1, 32'h60 + i, 1'b0);
        idle(1);
        chk("t6_mid_drain", rcache, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rcache", rcache, 0);
        chk("t6_c2m", cache2mem, 0);
        chk("t6_count", count, 0);
        chk("t6_drained", drained, 0);
        chk("t6_ready", in_ready, 1);
        @(negedge clk);
        chk("t6_hold_rcache", rcache, 0);
        chk("t6_hold_count", count, 0);
        rstn = 1'b1;
        model_reset();
        step(1'b1, 32'h55, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        wait_flush(20);
        idle(3);
        chk("t6_nwords", got.size(), 1);
        if (got.size() == 1) chk("t6_word", got[0], 32'h55);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, !flush_win && ($urandom_range(0, 31) == 0));
        end
        if (!flush_win) step(1'b0, 32'h0, 1'b1);
        wait_flush(100);
        chk("rnd_final_count", count, 0);
        chk("rnd_model_empty", m_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
